ucc8_seq_ctrl: RTL and testbench
================================

UCC8_SEQ_CTRL -- requirements
Module: ucc8_seq_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; single clock domain.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: start  input  1  run request; sampled only in IDLE.
REQ-004 SHALL have port: stop  input  1  abort request; sampled in LOAD and RUN.
REQ-005 SHALL have port: dir  input  1  count direction, 1 = up, 0 = down; latched on start.
REQ-006 SHALL have port: load_val  input  8  counter start value; latched on start.
REQ-007 SHALL have port: period_cnt  input  4  terminal-count periods to run, 0 = continuous; latched on start.
REQ-008 SHALL have port: cnt_cout  input  1  counter terminal carry: 0xFF when counting up, 0x00 when counting down, with cin=1.
REQ-009 SHALL have port: cnt_pin  output  8  counter parallel-load data; equals latched load_val.
REQ-010 SHALL have port: cnt_min  output  2  counter mode: 00 hold, 01 count down, 10 count up, 11 parallel load.
REQ-011 SHALL have port: cnt_cin  output  1  counter carry-in enable.
REQ-012 SHALL have port: busy  output  1  high in LOAD and RUN.
REQ-013 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port: periods_done  output  4  completed terminal-count periods in the current run.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN, DONE; all outputs Moore-decoded from state and registers.
REQ-016 IDLE SHALL drive cnt_min=00 and cnt_cin=0; start=1 at an edge -> latch dir/load_val/period_cnt, clear periods_done, next state LOAD.
REQ-017 LOAD SHALL drive cnt_min=11 and cnt_cin=0 for exactly one cycle, then go to RUN; the counter takes load_val at that edge.
REQ-018 RUN SHALL drive cnt_cin=1 and cnt_min=10 if latched dir=1, else 01.
REQ-019 In RUN, cnt_cout=1 at an edge SHALL increment periods_done, saturating at 15.
REQ-020 In RUN, if period_cnt!=0 and periods_done+1==period_cnt when cnt_cout=1, next state SHALL be DONE.
REQ-021 period_cnt=0 SHALL run until stop; periods_done saturates, and RUN never goes to DONE.
REQ-022 DONE SHALL drive cnt_min=00, cnt_cin=0, done=1 for one cycle, then go to IDLE; periods_done holds until the next accepted start.
REQ-023 stop=1 in LOAD or RUN SHALL go to IDLE next edge with no done pulse; stop has priority over cnt_cout in the same cycle.
REQ-024 start SHALL be ignored in LOAD, RUN and DONE; input changes after acceptance SHALL NOT affect the run.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, cnt_pin=0x00, cnt_min=00, cnt_cin=0, busy=0, done=0, periods_done=0, and clear latched dir/period_cnt, independent of clk.
REQ-026 Reset mid-run SHALL abort without a done pulse; the first start after deassertion behaves as in REQ-016.

Configuration
REQ-027 Macro UCC8_SEQ_CTRL_AUTORELOAD_EN SHALL select the terminal-count action.
REQ-028 With the macro defined, a non-final cnt_cout in RUN SHALL go to LOAD (reload load_val, one cycle), then back to RUN.
REQ-029 Without the macro, a non-final cnt_cout SHALL stay in RUN, so the counter wraps naturally (0xFF->0x00 up, 0x00->0xFF down).

Verification
REQ-030 rst pulse mid-RUN between clock edges -> all outputs zero/IDLE immediately, with no done pulse.
REQ-031 start, load_val=0xFD, dir=1, period_cnt=1 -> LOAD 1 cycle, RUN, counter FD,FE,FF -> DONE pulse, periods_done=1, cnt_min back to 00.
REQ-032 start, load_val=0x02, dir=0, period_cnt=2, macro defined -> counts 02,01,00, reload 02, counts 02,01,00 -> done, periods_done=2.
REQ-033 Same as REQ-032 without the macro -> second period covers the 256-step wrap 0xFF..0x00; done after 259 RUN cycles total.
REQ-034 period_cnt=0, stop asserted after 3 terminal counts, with cnt_cout=1 in the same cycle -> IDLE, no done, periods_done=3.
REQ-035 start held high throughout RUN with a changed load_val -> ignored; cnt_pin keeps the originally latched value.

Source files
------------

// File: rtl/ucc8_seq_ctrl.sv
// ucc8_seq_ctrl: sequencer for an external 8-bit up/down counter.
// Runs a latched number of terminal-count periods (0 = run until stop).
// Optional macro UCC8_SEQ_CTRL_AUTORELOAD_EN: a non-final terminal count
// reloads load_val through LOAD; otherwise the counter wraps in RUN.
module ucc8_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic [7:0] load_val,
  input  logic [3:0] period_cnt,
  input  logic       cnt_cout,
  output logic [7:0] cnt_pin,
  output logic [1:0] cnt_min,
  output logic       cnt_cin,
  output logic       busy,
  output logic       done,
  output logic [3:0] periods_done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic       dir_q, dir_d;
  logic [7:0] load_val_q, load_val_d;
  logic [3:0] period_cnt_q, period_cnt_d;
  logic [3:0] periods_done_q, periods_done_d;
  logic [3:0] periods_inc;
  logic       last_period;

  // state and run-parameter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      dir_q          <= 1'b0;
      load_val_q     <= '0;
      period_cnt_q   <= '0;
      periods_done_q <= '0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      load_val_q     <= load_val_d;
      period_cnt_q   <= period_cnt_d;
      periods_done_q <= periods_done_d;
    end
  end

  // next-state, parameter latch and period counting
  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    load_val_d     = load_val_q;
    period_cnt_d   = period_cnt_q;
    periods_done_d = periods_done_q;
    periods_inc    = (periods_done_q == '1) ? periods_done_q : periods_done_q + 4'd1;
    // widened compare so a saturated count can never alias a match
    last_period    = (period_cnt_q != '0) &&
                     (({1'b0, periods_done_q} + 5'd1) == {1'b0, period_cnt_q});
    case (state_q)
      IDLE: begin
        if (start) begin
          dir_d          = dir;
          load_val_d     = load_val;
          period_cnt_d   = period_cnt;
          periods_done_d = '0;
          state_d        = LOAD;
        end
      end
      LOAD: begin
        state_d = stop ? IDLE : RUN;
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_cout) begin
          periods_done_d = periods_inc;
          if (last_period) begin
            state_d = DONE;
          end else begin
`ifdef UCC8_SEQ_CTRL_AUTORELOAD_EN
            state_d = LOAD;
`else
            state_d = RUN;
`endif
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    cnt_pin      = load_val_q;
    periods_done = periods_done_q;
    cnt_min      = 2'b00;
    cnt_cin      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      LOAD: begin
        cnt_min = 2'b11;
        busy    = 1'b1;
      end
      RUN: begin
        cnt_min = dir_q ? 2'b10 : 2'b01;
        cnt_cin = 1'b1;
        busy    = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ucc8_seq_ctrl.sv
// Bench for ucc8_seq_ctrl with an external counter model and a per-cycle
// expected-output trace derived from period lengths.
module tb_ucc8_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, dir, cnt_cout;
  logic [7:0] load_val, cnt_pin;
  logic [3:0] period_cnt, periods_done;
  logic [1:0] cnt_min;
  logic       cnt_cin, busy, done;
  logic [7:0] cnt_q;

  int checks = 0;
  int errors = 0;

`ifdef UCC8_SEQ_CTRL_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] min;
    logic       cin;
    logic       busy;
    logic       done;
    logic [3:0] pd;
  } exp_t;

  exp_t tr[$];
  int   ends[$];

  always #5 clk = ~clk;

  ucc8_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
    .load_val(load_val), .period_cnt(period_cnt), .cnt_cout(cnt_cout),
    .cnt_pin(cnt_pin), .cnt_min(cnt_min), .cnt_cin(cnt_cin),
    .busy(busy), .done(done), .periods_done(periods_done)
  );

  // external counter
  always @(posedge clk) begin
    case (cnt_min)
      2'b11: cnt_q <= cnt_pin;
      2'b10: if (cnt_cin) cnt_q <= cnt_q + 8'd1;
      2'b01: if (cnt_cin) cnt_q <= cnt_q - 8'd1;
      default: ;
    endcase
  end
  assign cnt_cout = cnt_cin && ((cnt_min == 2'b10 && cnt_q == 8'hFF) ||
                                (cnt_min == 2'b01 && cnt_q == 8'h00));

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [1:0] m, input logic c, input logic b,
                              input logic d, input logic [3:0] p);
    exp_t e;
    e.min = m; e.cin = c; e.busy = b; e.done = d; e.pd = p;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e, input logic [7:0] pin);
    chk({tag, "/cnt_min"}, {6'd0, cnt_min}, {6'd0, e.min});
    chk({tag, "/cnt_cin"}, {7'd0, cnt_cin}, {7'd0, e.cin});
    chk({tag, "/busy"}, {7'd0, busy}, {7'd0, e.busy});
    chk({tag, "/done"}, {7'd0, done}, {7'd0, e.done});
    chk({tag, "/periods_done"}, {4'd0, periods_done}, {4'd0, e.pd});
    chk({tag, "/cnt_pin"}, cnt_pin, pin);
  endtask

  // Expected trace: one LOAD, then periods of RUN cycles whose length is the
  // distance to the terminal value; later periods are 256 long when wrapping.
  task automatic build(input logic [7:0] ld, input logic d, input logic [3:0] pc);
    int pd;
    int steps;
    bit first;
    logic [1:0] rm;
    tr.delete();
    ends.delete();
    pd = 0;
    first = 1'b1;
    rm = d ? 2'b10 : 2'b01;
    tr.push_back(mk(2'b11, 1'b0, 1'b1, 1'b0, 4'd0));
    forever begin
      if (first || AUTORELOAD) steps = d ? (256 - int'(ld)) : (int'(ld) + 1);
      else steps = 256;
      first = 1'b0;
      for (int i = 0; i < steps; i++) tr.push_back(mk(rm, 1'b1, 1'b1, 1'b0, 4'(pd)));
      ends.push_back(tr.size() - 1);
      if (pd < 15) pd++;
      if (pc != 0 && pd == int'(pc)) begin
        tr.push_back(mk(2'b00, 1'b0, 1'b0, 1'b1, 4'(pd)));
        tr.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 4'(pd)));
        return;
      end
      if (pc == 0 && ends.size() >= 18) return;
      if (AUTORELOAD) tr.push_back(mk(2'b11, 1'b0, 1'b1, 1'b0, 4'(pd)));
    end
  endtask

  // stop_sel: -1 no stop, -2 random stop, N>=0 stop on the (N+1)th terminal count
  task automatic do_run(input string tag, input logic [7:0] ld, input logic d,
                        input logic [3:0] pc, input int stop_sel, input bit hold);
    int k;
    int n;
    exp_t last;
    build(ld, d, pc);
    if (stop_sel == -1) k = -1;
    else if (stop_sel == -2) k = int'($urandom_range(tr.size() - 3, 0));
    else k = ends[stop_sel];
    if (k >= 0) begin
      while (tr.size() > k + 1) void'(tr.pop_back());
      last = tr[k];
      tr.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, last.pd));
    end
    n = tr.size();
    @(negedge clk);
    start = 1'b1; load_val = ld; dir = d; period_cnt = pc; stop = 1'b0;
    for (int idx = 0; idx < n; idx++) begin
      @(posedge clk); #1;
      check_outputs(tag, tr[idx], ld);
      @(negedge clk);
      stop = (idx == k);
      start = (idx == n - 1) ? 1'b0 : (hold ? 1'b1 : 1'($urandom));
      load_val = 8'($urandom);
      dir = 1'($urandom);
      period_cnt = 4'($urandom);
    end
    @(posedge clk); #1;
    check_outputs({tag, "/idle_hold"}, tr[n - 1], ld);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0;
    load_val = '0; period_cnt = '0;
    #2;
    check_outputs("reset", mk(2'b00, 1'b0, 1'b0, 1'b0, 4'd0), 8'h00);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_outputs("idle", mk(2'b00, 1'b0, 1'b0, 1'b0, 4'd0), 8'h00);

    do_run("up_fd_1", 8'hFD, 1'b1, 4'd1, -1, 1'b0);
    do_run("down_02_2", 8'h02, 1'b0, 4'd2, -1, 1'b0);
    do_run("up_ff_3", 8'hFF, 1'b1, 4'd3, -1, 1'b0);
    do_run("down_00_2", 8'h00, 1'b0, 4'd2, -1, 1'b0);

    do_run("cont_stop3", 8'($urandom), 1'b1, 4'd0, 3, 1'b0);
    chk("cont_stop3/pd_final", {4'd0, periods_done}, 8'd3);

    do_run("cont_sat", 8'hF0, 1'b0, 4'd0, 16, 1'b0);
    chk("cont_sat/pd_final", {4'd0, periods_done}, 8'd15);

    do_run("hold_start", 8'h33, 1'b1, 4'd1, -1, 1'b1);

    for (int r = 0; r < 8; r++) begin
      do_run($sformatf("rand%0d", r), 8'($urandom), 1'($urandom),
             4'($urandom_range(4, 1)), ((r % 2) == 1) ? -2 : -1, 1'b0);
    end

    // asynchronous reset between edges, mid-run
    @(negedge clk);
    start = 1'b1; load_val = 8'hFE; dir = 1'b1; period_cnt = 4'd5;
    @(negedge clk); start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst/busy", {7'd0, busy}, 8'd1);
    chk("pre_rst/pd", {4'd0, periods_done}, 8'd1);
    #2; rst = 1'b1;
    #1;
    check_outputs("mid_rst", mk(2'b00, 1'b0, 1'b0, 1'b0, 4'd0), 8'h00);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_outputs("post_rst", mk(2'b00, 1'b0, 1'b0, 1'b0, 4'd0), 8'h00);

    do_run("after_rst", 8'h05, 1'b0, 4'd1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
